// File: rtl/oled_text_refresh.sv
// oled_text_refresh: text buffer front end that powers the OLED panel and re-renders dirty frames
module oled_text_refresh #(
  parameter int COLS = 16,
  parameter int ROWS = 4,
  parameter bit AUTO_START = 1'b1,
  parameter INIT_FILE = "",
  localparam int A_W = $clog2(ROWS) + $clog2(COLS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           host_wr_en,
  input  logic [A_W-1:0] host_wr_addr,
  input  logic [7:0]     host_wr_data,
  input  logic           refresh_req,
  input  logic           disp_enable,
  output logic           ctl_disp_on_start,
  input  logic           ctl_disp_on_ready,
  output logic           ctl_disp_off_start,
  input  logic           ctl_disp_off_ready,
  output logic           ctl_write_start,
  output logic [7:0]     ctl_write_ascii,
  output logic [A_W+2:0] ctl_write_base_addr,
  input  logic           ctl_write_ready,
  output logic           ctl_update_start,
  output logic           ctl_update_clear,
  input  logic           ctl_update_ready,
  output logic           busy,
  output logic           disp_is_on,
  output logic [15:0]    frames_done
);
  typedef enum logic [2:0] {OFF, PWR_ON, IDLE, FETCH, LOAD, WR_WAIT, UPD_WAIT, PWR_OFF} state_t;
  localparam logic [A_W-1:0] LAST = A_W'(ROWS * COLS - 1);
  state_t state;
  logic [7:0] mem [ROWS*COLS];
  logic [7:0] rd_data;
  logic [A_W-1:0] addr;
  logic dirty, low_seen, pend, cur_ready, done;
  always_ff @(posedge clk) begin
    if (host_wr_en) mem[host_wr_addr] <= host_wr_data;
    if (state == FETCH) rd_data <= mem[addr];
  end
  always_comb begin
    cur_ready = state == PWR_ON  ? ctl_disp_on_ready :
                state == PWR_OFF ? ctl_disp_off_ready :
                state == WR_WAIT ? ctl_write_ready : ctl_update_ready;
    done = low_seen & cur_ready;
  end
  assign ctl_update_clear = 1'b0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= AUTO_START ? PWR_ON : OFF;
      pend <= AUTO_START;
      dirty <= 1'b1;
      addr <= '0;
      low_seen <= 1'b0;
      ctl_disp_on_start <= 1'b0;
      ctl_disp_off_start <= 1'b0;
      ctl_write_start <= 1'b0;
      ctl_update_start <= 1'b0;
      ctl_write_ascii <= '0;
      ctl_write_base_addr <= '0;
      busy <= 1'b0;
      disp_is_on <= 1'b0;
      frames_done <= '0;
    end else begin
      ctl_disp_on_start <= 1'b0;
      ctl_disp_off_start <= 1'b0;
      ctl_write_start <= 1'b0;
      ctl_update_start <= 1'b0;
      busy <= !(state inside {OFF, IDLE});
      if (!cur_ready) low_seen <= 1'b1;
      if (host_wr_en | refresh_req) dirty <= 1'b1;
      case (state)
        OFF: if (disp_enable & ctl_disp_on_ready) begin
          ctl_disp_on_start <= 1'b1;
          low_seen <= 1'b0;
          state <= PWR_ON;
        end
        PWR_ON: if (pend) begin
          if (ctl_disp_on_ready) begin
            ctl_disp_on_start <= 1'b1;
            low_seen <= 1'b0;
            pend <= 1'b0;
          end
        end else if (done) begin
          disp_is_on <= 1'b1;
          state <= IDLE;
        end
        IDLE: if (!disp_enable & ctl_disp_off_ready) begin
          ctl_disp_off_start <= 1'b1;
          disp_is_on <= 1'b0;
          low_seen <= 1'b0;
          state <= PWR_OFF;
        end else if (dirty & ctl_write_ready) begin
          addr <= '0;
          dirty <= host_wr_en | refresh_req;
          state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: if (ctl_write_ready) begin
          ctl_write_ascii <= rd_data;
          ctl_write_base_addr <= {addr, 3'b000};
          ctl_write_start <= 1'b1;
          low_seen <= 1'b0;
          state <= WR_WAIT;
        end
        WR_WAIT: if (done) begin
          if (addr != LAST) begin
            addr <= addr + 1'b1;
            state <= FETCH;
          end else if (ctl_update_ready) begin
            ctl_update_start <= 1'b1;
            low_seen <= 1'b0;
            state <= UPD_WAIT;
          end
        end
        UPD_WAIT: if (done) begin
          frames_done <= frames_done + 1'b1;
          addr <= '0;
          state <= IDLE;
        end
        PWR_OFF: if (done) state <= OFF;
        default: state <= OFF;
      endcase
    end
  end
endmodule

// File: tb/tb_oled_text_refresh.sv
// tb_oled_text_refresh: directed checks of power sequencing, rendering and handshakes
module tb_oled_text_refresh;
  logic clk = 0, rst = 1, host_wr_en = 0, refresh_req = 0, disp_enable = 1;
  logic [5:0] host_wr_addr = 0;
  logic [7:0] host_wr_data = 0;
  logic on_start, off_start, write_start, update_start, update_clear, busy, disp_is_on;
  logic [7:0] write_ascii;
  logic [8:0] write_base;
  logic [15:0] frames_done;
  logic [3:0] hold = 0, rdy, st, st_q = 0;
  int cnt [4] = '{0, 0, 0, 0};
  int n_on = 0, n_off = 0, n_wr = 0, n_upd = 0, viol = 0, vecs = 0, miss = 0;
  logic [7:0] wr_ascii [1024];
  logic [8:0] wr_base [1024];
  logic b_on, b_off, b_wr, b_upd, b_clr, b_busy, b_is_on;
  logic [7:0] b_ascii;
  logic [10:0] b_base, last_b = 0;
  logic [15:0] b_frames;
  logic [3:0] rdy_b = '1;
  int n_wr_b = 0;

  always #5 clk = ~clk;

  oled_text_refresh dut (
    .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .refresh_req(refresh_req), .disp_enable(disp_enable),
    .ctl_disp_on_start(on_start), .ctl_disp_on_ready(rdy[0]),
    .ctl_disp_off_start(off_start), .ctl_disp_off_ready(rdy[1]),
    .ctl_write_start(write_start), .ctl_write_ascii(write_ascii),
    .ctl_write_base_addr(write_base), .ctl_write_ready(rdy[2]),
    .ctl_update_start(update_start), .ctl_update_clear(update_clear),
    .ctl_update_ready(rdy[3]), .busy(busy), .disp_is_on(disp_is_on), .frames_done(frames_done)
  );

  oled_text_refresh #(.COLS(32), .ROWS(8)) big (
    .clk(clk), .rst(rst), .host_wr_en(1'b0), .host_wr_addr(8'h00),
    .host_wr_data(8'h00), .refresh_req(1'b0), .disp_enable(1'b1),
    .ctl_disp_on_start(b_on), .ctl_disp_on_ready(rdy_b[0]),
    .ctl_disp_off_start(b_off), .ctl_disp_off_ready(rdy_b[1]),
    .ctl_write_start(b_wr), .ctl_write_ascii(b_ascii),
    .ctl_write_base_addr(b_base), .ctl_write_ready(rdy_b[2]),
    .ctl_update_start(b_upd), .ctl_update_clear(b_clr),
    .ctl_update_ready(rdy_b[3]), .busy(b_busy), .disp_is_on(b_is_on), .frames_done(b_frames)
  );

  // controller model: each command drops ready for 10 cycles after its start; hold forces it low
  assign st = {update_start, write_start, off_start, on_start};
  always_comb for (int i = 0; i < 4; i++) rdy[i] = cnt[i] == 0 && !hold[i];
  always @(posedge clk) for (int i = 0; i < 4; i++) cnt[i] <= st[i] ? 10 : cnt[i] > 0 ? cnt[i] - 1 : 0;
  always @(posedge clk) rdy_b <= ~{b_upd, b_wr, b_off, b_on};

  always @(negedge clk) begin
    if (on_start) n_on++;
    if (off_start) n_off++;
    if (update_start) n_upd++;
    if (write_start) begin
      if (n_wr < 1024) begin
        wr_ascii[n_wr] = write_ascii;
        wr_base[n_wr] = write_base;
      end
      n_wr++;
    end
    if ((st & ~rdy) != 0 || (st & st_q) != 0 || update_clear) viol++;
    st_q = st;
    if (b_wr) begin
      n_wr_b++;
      last_b = b_base;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_frames(input logic [15:0] f);
    for (int i = 0; i < 5000 && frames_done != f; i++) @(negedge clk);
    chk("frames_reached", frames_done, f);
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 5000 && n_wr < n; i++) @(negedge clk);
    chk("write_reached", n_wr, n);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    host_wr_en = 1; host_wr_addr = a; host_wr_data = d;
    @(negedge clk);
    host_wr_en = 0;
  endtask

  task automatic refresh();
    refresh_req = 1;
    @(negedge clk);
    refresh_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int s, u, o;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_starts", st, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_is_on", disp_is_on, 0);
    rst = 0;
    wait_frames(1);
    chk("t1_on_pulses", n_on, 1);
    chk("t1_writes", n_wr, 64);
    chk("t1_base0", wr_base[0], 9'h000);
    chk("t1_base1", wr_base[1], 9'h008);
    chk("t1_base63", wr_base[63], 9'h1F8);
    chk("t1_updates", n_upd, 1);
    chk("t1_is_on", disp_is_on, 1);
    repeat (5) @(negedge clk);
    chk("t1_busy", busy, 0);
    s = n_wr;
    host_write(6'h15, 8'h41);
    wait_frames(2);
    chk("t2_writes", n_wr - s, 64);
    chk("t2_ascii22", wr_ascii[s + 21], 8'h41);
    chk("t2_base22", wr_base[s + 21], 9'h0A8);
    repeat (200) @(negedge clk);
    chk("t2_one_frame", frames_done, 2);
    chk("t2_busy", busy, 0);
    chk("big_writes", n_wr_b, 256);
    chk("big_last_base", last_b, 11'h7F8);
    chk("big_frames", b_frames, 1);
    s = n_wr;
    refresh();
    wait_wr(s + 31);
    host_write(6'h05, 8'h42);
    wait_frames(4);
    repeat (200) @(negedge clk);
    chk("t3_frames", frames_done, 4);
    chk("t3_writes", n_wr - s, 128);
    chk("t3_rescan_data", wr_ascii[s + 69], 8'h42);
    s = n_wr; u = n_upd;
    refresh();
    wait_wr(s + 11);
    disp_enable = 0;
    for (int i = 0; i < 5000 && n_off == 0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("t4_writes", n_wr - s, 64);
    chk("t4_updates", n_upd - u, 1);
    chk("t4_off_pulses", n_off, 1);
    chk("t4_is_on", disp_is_on, 0);
    chk("t4_busy", busy, 0);
    chk("t4_frames", frames_done, 5);
    refresh();
    repeat (20) @(negedge clk);
    chk("t4_stays_off", n_on, 1);
    disp_enable = 1;
    wait_frames(6);
    chk("t4_on_pulses", n_on, 2);
    chk("t4_is_on_again", disp_is_on, 1);
    s = n_wr; u = n_upd;
    refresh();
    wait_wr(s + 5);
    hold[2] = 1;
    repeat (1000) @(negedge clk);
    chk("t5_stalled_writes", n_wr, s + 5);
    chk("t5_stalled_updates", n_upd, u);
    hold[2] = 0;
    wait_frames(7);
    chk("t5_writes", n_wr - s, 64);
    s = n_wr; o = n_on;
    refresh();
    wait_wr(s + 3);
    rst = 1;
    @(negedge clk);
    chk("t6_starts", st, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frames", frames_done, 0);
    rst = 0;
    wait_frames(1);
    chk("t6_on_pulses", n_on, o + 1);
    chk("t6_rescan_base", wr_base[s + 3], 9'h000);
    chk("t6_writes", n_wr - s, 67);
    chk("t6_is_on", disp_is_on, 1);
    chk("protocol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
